full_adder_cc: RTL and testbench



---
 rtl/full_adder_cc.sv | 107 ++++++++++
 tb/tb_full_adder_cc.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/full_adder_cc.sv
// full_adder_cc: registered WIDTH-bit ripple-carry adder.
// {cout, sum} = a + b + cin is captured on each rising edge where in_valid is
// high. The outputs hold their last result while in_valid is low.
// Optional feature macro: FULL_ADDER_CC_OVF_EN adds a registered signed
// overflow flag on port ovf.
module full_adder_cc #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef FULL_ADDER_CC_OVF_EN
    output logic             ovf,
`endif
    output logic             out_valid
);

    // Sum bit of one full-adder cell.
    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    // Carry-out of one full-adder cell (majority of the three inputs).
    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    // Ripple chain of WIDTH cells; result bit WIDTH is the MSB carry-out.
    // The chain is kept in a function-local variable so the carry vector is
    // not a self-referencing combinational signal.
    function automatic logic [WIDTH:0] ripple_add(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             c0
    );
        logic [WIDTH:0] res;
        logic           c;
        res = '0;
        c   = c0;
        for (int i = 0; i < WIDTH; i++) begin
            res[i] = fa_sum(x[i], y[i], c);
            c      = fa_carry(x[i], y[i], c);
        end
        res[WIDTH] = c;
        return res;
    endfunction

    logic [WIDTH:0]   add_s;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             out_valid_r;
`ifdef FULL_ADDER_CC_OVF_EN
    logic             ovf_s;
    logic             ovf_r;
`endif

    // Combinational ripple-carry addition of the current operands.
    always_comb begin
        add_s = ripple_add(a, b, cin);
    end

`ifdef FULL_ADDER_CC_OVF_EN
    // Signed overflow: like-signed operands whose sum flips sign.
    always_comb begin
        ovf_s = 1'b0;
        if ((a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1])) begin
            ovf_s = 1'b1;
        end else begin
            ovf_s = 1'b0;
        end
    end
`endif

    // Output register set: load on in_valid, otherwise hold the result and drop valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r       <= '0;
            cout_r      <= 1'b0;
            out_valid_r <= 1'b0;
`ifdef FULL_ADDER_CC_OVF_EN
            ovf_r       <= 1'b0;
`endif
        end else if (in_valid) begin
            sum_r       <= add_s[WIDTH-1:0];
            cout_r      <= add_s[WIDTH];
            out_valid_r <= 1'b1;
`ifdef FULL_ADDER_CC_OVF_EN
            ovf_r       <= ovf_s;
`endif
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign sum       = sum_r;
    assign cout      = cout_r;
    assign out_valid = out_valid_r;
`ifdef FULL_ADDER_CC_OVF_EN
    assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_full_adder_cc.sv
// Self-checking bench for full_adder_cc: WIDTH=1, 8 and 16 instances share
// one clock and reset. Expected values come from plain integer arithmetic.
module tb_full_adder_cc;

    logic clk;
    logic rst_n;

    logic       v1, cin1;
    logic [0:0] a1, b1, s1;
    logic       co1, ov1;

    logic       v8, cin8;
    logic [7:0] a8, b8, s8;
    logic       co8, ov8;

    logic        v16, cin16;
    logic [15:0] a16, b16, s16;
    logic        co16, ov16;

    int checks = 0;
    int errors = 0;

`ifdef FULL_ADDER_CC_OVF_EN
    logic ovf1, ovf8, ovf16;
`endif

    full_adder_cc #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(cin1),
        .sum(s1), .cout(co1),
`ifdef FULL_ADDER_CC_OVF_EN
        .ovf(ovf1),
`endif
        .out_valid(ov1)
    );

    full_adder_cc #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(cin8),
        .sum(s8), .cout(co8),
`ifdef FULL_ADDER_CC_OVF_EN
        .ovf(ovf8),
`endif
        .out_valid(ov8)
    );

    full_adder_cc #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .a(a16), .b(b16), .cin(cin16),
        .sum(s16), .cout(co16),
`ifdef FULL_ADDER_CC_OVF_EN
        .ovf(ovf16),
`endif
        .out_valid(ov16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Signed overflow of x + y + c for a given width, from the true integer result.
    function automatic logic sovf(input longint x, input longint y, input longint c, input int w);
        longint sx, sy, r, lo, hi;
        sx = (x >= (64'sd1 <<< (w - 1))) ? x - (64'sd1 <<< w) : x;
        sy = (y >= (64'sd1 <<< (w - 1))) ? y - (64'sd1 <<< w) : y;
        r  = sx + sy + c;
        lo = -(64'sd1 <<< (w - 1));
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        return (r < lo) || (r > hi);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp;
        longint e17;
        logic   e_ovf, e_v;
        int     ra, rb, rc;

        rst_n = 1'b1;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        v8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        v16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0;

        // Reset state, asserted between edges.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sum8", 64'(s8), 64'h0);
        chk("rst_cout8", 64'(co8), 64'h0);
        chk("rst_valid8", 64'(ov8), 64'h0);
        chk("rst_valid1", 64'(ov1), 64'h0);
`ifdef FULL_ADDER_CC_OVF_EN
        chk("rst_ovf8", 64'(ovf8), 64'h0);
`endif
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive 1-bit truth table.
        for (int i = 0; i < 8; i++) begin
            a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i); v1 = 1'b1;
            tick();
            exp = ((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1);
            chk($sformatf("w1_%0d", i), {62'h0, co1, s1}, 64'(exp));
            chk("w1_valid", 64'(ov1), 64'h1);
        end
        v1 = 1'b0;

        // Carry propagation across all 8 bits.
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; v8 = 1'b1;
        tick();
        chk("w8_ripple_sum", 64'(s8), 64'h00);
        chk("w8_ripple_cout", 64'(co8), 64'h1);
`ifdef FULL_ADDER_CC_OVF_EN
        chk("w8_ripple_ovf", 64'(ovf8), 64'(sovf(64'hFF, 64'h00, 64'h1, 8)));
`endif
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
        tick();
        chk("w8_7f_sum", 64'(s8), 64'h80);
        chk("w8_7f_cout", 64'(co8), 64'h0);
`ifdef FULL_ADDER_CC_OVF_EN
        chk("w8_7f_ovf", 64'(ovf8), 64'h1);
`endif

        // Valid gating and hold.
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        tick();
        chk("w8_gate_sum", 64'(s8), 64'h46);
        chk("w8_gate_valid", 64'(ov8), 64'h1);
        v8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        tick();
        chk("w8_hold_sum", 64'(s8), 64'h46);
        chk("w8_hold_cout", 64'(co8), 64'h0);
        chk("w8_hold_valid", 64'(ov8), 64'h0);

        // Mid-stream asynchronous reset.
        v8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        tick();
        chk("w8_pre_rst", 64'(s8), 64'h46);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sum", 64'(s8), 64'h0);
        chk("mid_rst_cout", 64'(co8), 64'h0);
        chk("mid_rst_valid", 64'(ov8), 64'h0);
`ifdef FULL_ADDER_CC_OVF_EN
        chk("mid_rst_ovf", 64'(ovf8), 64'h0);
`endif
        #1 rst_n = 1'b1;
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b1;
        tick();
        chk("post_rst_sum", 64'(s8), 64'h03);
        chk("post_rst_valid", 64'(ov8), 64'h1);
        v8 = 1'b0;

        // Randomized WIDTH=16 against an arithmetic model, including hold.
        e17 = 0; e_ovf = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            ra = int'($urandom_range(65535, 0));
            rb = int'($urandom_range(65535, 0));
            rc = int'($urandom_range(1, 0));
            e_v = 1'($urandom_range(1, 0));
            a16 = 16'(ra); b16 = 16'(rb); cin16 = 1'(rc); v16 = e_v;
            tick();
            if (e_v) begin
                e17   = longint'(ra) + longint'(rb) + longint'(rc);
                e_ovf = sovf(longint'(ra), longint'(rb), longint'(rc), 16);
            end
            chk("rnd_sum", 64'(s16), 64'(e17 % 65536));
            chk("rnd_cout", 64'(co16), 64'(e17 / 65536));
            chk("rnd_valid", 64'(ov16), 64'(e_v));
`ifdef FULL_ADDER_CC_OVF_EN
            chk("rnd_ovf", 64'(ovf16), 64'(e_ovf));
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
